// File: rtl/mips_ifu.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID register.
// Define MIPS_DELAY_SLOT_EN for delay-slot semantics; otherwise a redirect flushes IF/ID.
module mips_ifu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] jr_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_e;

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic [31:0] target;
  logic        redirect;
  logic        jr_misalign;
  npc_e        sel;

  assign imem_addr = pc_q;

  always_comb begin
    sel         = npc_e'(npc_sel);
    pc4         = pc_q + 32'd4;
    br_target   = id_pc4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    j_target    = {id_pc4[31:28], id_instr[25:0], 2'b00};
    jr_target   = {jr_addr[31:2], 2'b00};
    redirect    = 1'b0;
    target      = pc4;
    jr_misalign = 1'b0;
    // Redirects are decided only by a valid instruction sitting in ID.
    if (id_valid) begin
      unique case (sel)
        NPC_SEQ: redirect = 1'b0;
        NPC_BR: begin
          redirect = br_taken;
          target   = br_target;
        end
        NPC_J: begin
          redirect = 1'b1;
          target   = j_target;
        end
        NPC_JR: begin
          redirect    = 1'b1;
          target      = jr_target;
          jr_misalign = (jr_addr[1:0] != 2'b00);
        end
        default: redirect = 1'b0;
      endcase
    end
    if (!redirect) target = pc4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc4   <= RESET_PC;
      id_valid <= 1'b0;
      misalign <= 1'b0;
    end else if (!stall) begin
      pc_q   <= target;
      id_pc4 <= pc4;
`ifdef MIPS_DELAY_SLOT_EN
      id_instr <= imem_rdata;
      id_valid <= 1'b1;
`else
      if (redirect) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end else begin
        id_instr <= imem_rdata;
        id_valid <= 1'b1;
      end
`endif
      if (jr_misalign) misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_ifu.sv
// Self-checking bench for mips_ifu: directed scenarios followed by random control
// traffic, compared against a behavioural fetch model.
module tb_mips_ifu;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] jr_addr;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        misalign;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis;

  mips_ifu #(.RESET_PC(32'h0000_3000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .npc_sel(npc_sel), .br_taken(br_taken), .jr_addr(jr_addr),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a few planted instructions, everything else address-tagged.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3008) return 32'h1000_FFFE;  // beq, imm16 = -2
    if (a == 32'h0000_300C) return 32'h0800_0C10;  // j, instr_index 0xC10
    if (a == 32'h0000_3040) return 32'h1000_0004;  // beq, imm16 = +4
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".id_instr"}, id_instr, m_instr);
    chk({tag, ".id_pc4"}, id_pc4, m_pc4);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'h0; m_pc4 = 32'h0000_3000;
    m_valid = 1'b0; m_mis = 1'b0;
  endtask

  // One clock edge of the fetch stage, described by its architectural rules.
  task automatic model_step(input logic st, input logic [1:0] ns, input logic bt,
                            input logic [31:0] jra);
    logic        take;
    logic [31:0] tgt, seq;
    int          off;
    if (st) return;
    seq  = m_pc + 32'd4;
    take = m_valid && ((ns == 2'd1 && bt) || ns == 2'd2 || ns == 2'd3);
    tgt  = seq;
    if (take) begin
      if (ns == 2'd1) begin
        off = $signed(m_instr[15:0]);
        tgt = m_pc4 + 32'(off * 4);
      end else if (ns == 2'd2) begin
        tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      end else begin
        tgt = jra & 32'hFFFF_FFFC;
        if (jra % 4 != 0) m_mis = 1'b1;
      end
    end
`ifdef MIPS_DELAY_SLOT_EN
    m_instr = mem_word(m_pc); m_valid = 1'b1;
`else
    if (take) begin m_instr = 32'h0; m_valid = 1'b0; end
    else begin m_instr = mem_word(m_pc); m_valid = 1'b1; end
`endif
    m_pc4 = seq;
    m_pc  = tgt;
  endtask

  // Called at a negedge: drive inputs, advance one edge, check at the next negedge.
  task automatic cycle(input string tag, input logic st, input logic [1:0] ns,
                       input logic bt, input logic [31:0] jra);
    stall = st; npc_sel = ns; br_taken = bt; jr_addr = jra;
    imem_rdata = mem_word(imem_addr);
    model_step(st, ns, bt, jra);
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    int unsigned n;
    logic        st, bt;
    logic [1:0]  ns;
    logic [31:0] jra;

    reset = 1'b1; stall = 1'b0; npc_sel = 2'd0; br_taken = 1'b0;
    jr_addr = 32'h0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_all("reset");

    // First edge: ID empty, so a jump request must not redirect.
    cycle("seq0_nojump", 1'b0, 2'd2, 1'b1, 32'h0);
    chk("first_fetch_pc", imem_addr, 32'h0000_3004);
    chk("first_valid", {31'b0, id_valid}, 32'd1);
    cycle("seq1", 1'b0, 2'd0, 1'b0, 32'h0);
    cycle("seq2", 1'b0, 2'd0, 1'b0, 32'h0);
    chk("beq_in_id", id_instr, 32'h1000_FFFE);

    cycle("beq_taken", 1'b0, 2'd1, 1'b1, 32'h0);
    chk("br_target", imem_addr, 32'h0000_3004);
`ifdef MIPS_DELAY_SLOT_EN
    chk("br_slot_valid", {31'b0, id_valid}, 32'd1);
    chk("br_slot_pc4", id_pc4, 32'h0000_3010);
`else
    chk("br_bubble", {31'b0, id_valid}, 32'd0);
`endif

    // Advance until the j at 0x300C sits in ID, then take it.
    n = 0;
    while (!(m_valid && m_pc4 == 32'h0000_3010) && n < 8) begin
      cycle("seek_j", 1'b0, 2'd0, 1'b0, 32'h0);
      n++;
    end
    chk("seek_j_bound", {31'b0, n < 8}, 32'd1);
    cycle("jump", 1'b0, 2'd2, 1'b0, 32'h0);
    chk("j_target", imem_addr, 32'h0000_3040);

    n = 0;
    while (!(m_valid && m_instr == 32'h1000_0004) && n < 8) begin
      cycle("seek_beq2", 1'b0, 2'd0, 1'b0, 32'h0);
      n++;
    end
    chk("seek_beq2_bound", {31'b0, n < 8}, 32'd1);
    for (int i = 0; i < 3; i++) cycle("stall_hold", 1'b1, 2'd1, 1'b1, 32'h0);
    chk("stall_pc", imem_addr, 32'h0000_3044);
    cycle("stall_release", 1'b0, 2'd1, 1'b1, 32'h0);
    chk("stall_br_target", imem_addr, 32'h0000_3054);

    n = 0;
    while (!m_valid && n < 4) begin
      cycle("seek_jr", 1'b0, 2'd0, 1'b0, 32'h0);
      n++;
    end
    cycle("jr_misaligned", 1'b0, 2'd3, 1'b0, 32'h0000_3102);
    chk("jr_target", imem_addr, 32'h0000_3100);
    chk("jr_misalign", {31'b0, misalign}, 32'd1);
    for (int i = 0; i < 4; i++) cycle("misalign_sticky", 1'b0, 2'd0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a cycle with a redirect pending.
    n = 0;
    while (!m_valid && n < 4) begin
      cycle("seek_async", 1'b0, 2'd0, 1'b0, 32'h0);
      n++;
    end
    stall = 1'b0; npc_sel = 2'd2; br_taken = 1'b0;
    imem_rdata = mem_word(imem_addr);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_all("after_reset");

    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(3) == 0);
      ns  = 2'($urandom_range(3));
      bt  = 1'($urandom_range(1));
      jra = $urandom;
      if ($urandom_range(7) != 0) jra[1:0] = 2'b00;
      cycle("random", st, ns, bt, jra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
